dram_stream_out: RTL and testbench
==================================

Name: dram_stream_out

Overview:
- Downstream readout stage for data memory. Scans a contiguous byte region through the memory's external read port (ext_addr / ext_data) and streams the bytes out on a valid/ready interface.
- Used to dump the downsampled image after the processor halts, to a UART, testbench sink or host bridge.
- Holds a small prefetch FIFO so that a byte is delivered every cycle while out_ready stays high.

Parameters:
- ADDR_W, 19, width of memory byte address.
- DATA_W, 8, width of one memory word/pixel.
- MEM_LAST, 67000, highest legal memory address.
- FIFO_DEPTH, 4, prefetch FIFO entries; power of two, >= READ_LAT+2.
- READ_LAT, 1, cycles from ext_addr register update to ext_data valid for capture.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a transfer.
- base_addr  in  ADDR_W  first byte address, sampled with start.
- length  in  ADDR_W  number of bytes to send, sampled with start.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse when the last byte has been handshaken, or on a zero-length transfer.
- err  out  1  one-cycle pulse when start is rejected for an illegal range.
- ext_addr  out  ADDR_W  registered address to the memory external read port.
- ext_data  in  DATA_W  memory external read data.
- out_data  out  DATA_W  stream byte.
- out_valid  out  1  out_data valid.
- out_ready  in  1  sink accepts the byte when out_valid && out_ready at a rising edge.
- out_last  out  1  qualifies the final byte of the transfer.

Behaviour:
- Reset (rst=1 at a rising edge): state IDLE; busy=0, done=0, err=0, ext_addr=0, out_valid=0, out_last=0, out_data=0. FIFO, in-flight pipeline and counters are cleared.
- Reset mid-transfer aborts immediately. No done pulse, remaining bytes are dropped, FIFO is flushed.
- FSM states: IDLE, RUN, DRAIN.
- IDLE + start:
  - base_addr+length-1 > MEM_LAST (computed at ADDR_W+1 bits) with length != 0 -> err pulse next cycle, stay IDLE.
  - length == 0 -> done pulse next cycle, busy stays 0, no output.
  - Otherwise latch base/length, busy=1 next cycle, go to RUN.
- start while busy is ignored; no error is raised.
- RUN issue rule:
  - Issue one address per cycle while issued < length and fifo_count + inflight < FIFO_DEPTH.
  - Issue means ext_addr <= base + issued, and the in-flight shift register receives a tag carrying last = (issued == length-1).
  - ext_addr holds its last value when no address is issued.
- Capture: READ_LAT cycles after an issue, ext_data is written into the FIFO with the tag's last flag.
- RUN -> DRAIN when all length addresses have been issued.
- DRAIN -> IDLE on the handshake of the byte whose last=1. done pulses in the same cycle as the state change to IDLE (the registered cycle after the handshake); busy falls in that same cycle.
- Output:
  - out_valid = FIFO not empty; out_data/out_last come from the FIFO head.
  - Data and last are stable while out_valid=1 and out_ready=0.
- Simultaneous FIFO write and read in one cycle are both honoured; count is unchanged.
- Throughput: with out_ready held high, the first out_valid appears READ_LAT+1 cycles after busy rises. One byte per cycle follows with no bubbles.
- Back-pressure: issue stalls by credit, so the FIFO never overflows. No byte is dropped or duplicated.
- Address arithmetic is unsigned ADDR_W. Wrap cannot occur because the range check rejects it.
- A new start is accepted in the cycle done pulses.

Decomposition:
- Shared package holds:
  - ADDR_W, DATA_W, MEM_LAST constants (shared with data memory and control);
  - FSM state enum (IDLE/RUN/DRAIN);
  - a stream-beat struct {data, last}.
- One natural sub-module: sync_fifo, a parameterised depth/width synchronous FIFO with count output. It is reused for other stream stages.

Test Plan:
- Preload mem[100..103]=8'h11,22,33,44; start base=100, len=4, out_ready=1 -> bytes 11,22,33,44 on consecutive cycles; out_last only on 44; done 1 cycle after the 44 handshake.
- Same transfer with out_ready toggling 1,0,0,1,0,1... -> identical byte order; out_data stable during stalls; ext_addr never more than FIFO_DEPTH ahead of the accepted count.
- start base=66998, len=4 -> err pulse, busy stays 0, no out_valid. Then base=66997, len=4 -> 4 bytes ending at addr 67000.
- start len=0 -> done pulse next cycle, busy=0, out_valid=0 throughout.
- rst asserted 2 cycles into a len=16 transfer -> all outputs 0 next cycle, no done. A following start base=0, len=2 streams mem[0], mem[1] correctly.
- start asserted again while busy (base=5) -> ignored; the original transfer completes unchanged.

Source files
------------

// File: rtl/dram_stream_out_pkg.sv
// rtl/dram_stream_out_pkg.sv - shared memory geometry, readout FSM states and stream beat type
package dram_stream_out_pkg;

  localparam int ADDR_W   = 19;
  localparam int DATA_W   = 8;
  localparam int MEM_LAST = 67000;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              last;
  } beat_t;

endpackage

// File: rtl/dram_stream_out_sync_fifo.sv
// rtl/dram_stream_out_sync_fifo.sv - synchronous FIFO with occupancy count, DEPTH must be a power of two
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 9,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic [AW:0]      count
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign do_wr   = wr_en && (count != FULL_CNT);
  assign do_rd   = rd_en && (count != '0);
  assign empty   = (count == '0);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_wr) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dram_stream_out.sv
// rtl/dram_stream_out.sv - scans a memory byte range over the external read port and streams it out
module dram_stream_out
  import dram_stream_out_pkg::*;
#(
  parameter int ADDR_W     = dram_stream_out_pkg::ADDR_W,
  parameter int DATA_W     = dram_stream_out_pkg::DATA_W,
  parameter int MEM_LAST   = dram_stream_out_pkg::MEM_LAST,
  parameter int FIFO_DEPTH = 4,
  parameter int READ_LAT   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] length,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last
);

  localparam int CW = $clog2(FIFO_DEPTH);

  state_t            state, state_nx;
  logic [ADDR_W-1:0] base_q, len_q, issued;
  logic [READ_LAT-1:0] pipe_vld, pipe_last;
  logic [CW:0]       fifo_cnt, inflight;
  logic [ADDR_W:0]   end_addr;
  logic              range_bad, issue, hs, fifo_empty;
  beat_t             head, wr_beat;

  assign end_addr  = {1'b0, base_addr} + {1'b0, length} - 1'b1;
  assign range_bad = (length != '0) && (end_addr > (ADDR_W+1)'(MEM_LAST));
  assign hs        = out_valid && out_ready;
  assign busy      = (state != IDLE);

  always_comb begin
    inflight = '0;
    for (int i = 0; i < READ_LAT; i++) inflight = inflight + (CW+1)'(pipe_vld[i]);
  end

  // Credit counts both buffered and in-flight reads so the FIFO can never overflow.
  always_comb begin
    state_nx = state;
    issue    = 1'b0;
    unique case (state)
      IDLE:  if (start && !range_bad && length != '0) state_nx = RUN;
      RUN: begin
        issue = (issued < len_q) &&
                ((CW+2)'(fifo_cnt) + (CW+2)'(inflight) < (CW+2)'(FIFO_DEPTH));
        if (issue && issued == len_q - 1'b1) state_nx = DRAIN;
      end
      DRAIN: if (hs && out_last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      base_q    <= '0;
      len_q     <= '0;
      issued    <= '0;
      ext_addr  <= '0;
      pipe_vld  <= '0;
      pipe_last <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (state == IDLE && start) begin
        if (range_bad)          err  <= 1'b1;
        else if (length == '0)  done <= 1'b1;
        else begin
          base_q <= base_addr;
          len_q  <= length;
          issued <= '0;
        end
      end
      if (state == DRAIN && hs && out_last) done <= 1'b1;
      if (issue) begin
        ext_addr <= base_q + issued;
        issued   <= issued + 1'b1;
      end
      pipe_vld[0]  <= issue;
      pipe_last[0] <= issue && (issued == len_q - 1'b1);
      for (int i = 1; i < READ_LAT; i++) begin
        pipe_vld[i]  <= pipe_vld[i-1];
        pipe_last[i] <= pipe_last[i-1];
      end
    end
  end

  assign wr_beat = '{data: ext_data, last: pipe_last[READ_LAT-1]};

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(beat_t))
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (pipe_vld[READ_LAT-1]),
    .wr_data (wr_beat),
    .rd_en   (hs),
    .rd_data (head),
    .empty   (fifo_empty),
    .count   (fifo_cnt)
  );

  assign out_valid = !fifo_empty;
  assign out_data  = head.data;
  assign out_last  = head.last;

endmodule

// File: tb/tb_dram_stream_out.sv
// tb/tb_dram_stream_out.sv - directed self-checking bench for dram_stream_out
module tb_dram_stream_out;

  localparam int AW = 19;
  localparam int DW = 8;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst, start, out_ready;
  logic [AW-1:0] base_addr, length;
  logic          busy, done, err, out_valid, out_last;
  logic [AW-1:0] ext_addr;
  logic [DW-1:0] ext_data, out_data;

  logic [DW-1:0] mem [0:67000];
  assign ext_data = mem[ext_addr];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dram_stream_out dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
    .busy(busy), .done(done), .err(err), .ext_addr(ext_addr), .ext_data(ext_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pulse_start(input logic [AW-1:0] b, input logic [AW-1:0] l);
    @(negedge clk);
    start = 1'b1; base_addr = b; length = l;
    @(negedge clk);
    start = 1'b0;
  endtask

  // mode 0: ready always high; mode 1: ready pattern 1,0,0,1,0,1 repeating
  task automatic run_xfer(input logic [AW-1:0] b, input logic [AW-1:0] l,
                          input int mode, input bit inject);
    int got, first_v, last_hs, viol, ahead;
    bit hs_pend, prev_stall, fin, rdy;
    logic [DW-1:0] prev_d;
    logic prev_l;
    bit pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    got = 0; first_v = -1; last_hs = -1; viol = 0;
    hs_pend = 0; prev_stall = 0; fin = 0; prev_d = '0; prev_l = 0;
    out_ready = (mode == 0) ? 1'b1 : 1'b0;
    pulse_start(b, l);
    check("busy_rise", busy, 1);
    for (int cyc = 0; cyc < 300 && !fin; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (hs_pend && got == int'(l)) begin
        check("done_pulse", done, 1);
        check("busy_fall", busy, 0);
        fin = 1;
      end else begin
        if (inject && cyc == 1) begin
          start = 1'b1; base_addr = 5; length = 3;
        end else start = 1'b0;
        if (out_valid && first_v < 0) first_v = cyc;
        if (prev_stall) begin
          check("stall_valid", out_valid, 1);
          check("stall_data", out_data, prev_d);
          check("stall_last", out_last, prev_l);
        end
        if (out_valid && got > 0) begin
          ahead = int'(ext_addr) - int'(b) + 1 - got;
          if (ahead > DEPTH) viol++;
        end
        rdy = (mode == 0) ? 1'b1 : pat[cyc % 6];
        out_ready = rdy;
        if (out_valid && rdy) begin
          check("byte_data", out_data, mem[int'(b) + got]);
          check("byte_last", out_last, (got == int'(l) - 1));
          got++;
          last_hs = cyc;
        end
        hs_pend = out_valid && rdy;
        prev_stall = out_valid && !rdy;
        prev_d = out_data;
        prev_l = out_last;
      end
    end
    start = 1'b0;
    if (!fin) check("xfer_timeout", 1, 0);
    check("byte_count", got, l);
    check("credit_ahead", viol, 0);
    if (mode == 0) begin
      check("first_valid_lat", first_v, 2);
      check("no_bubble", last_hs - first_v, int'(l) - 1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("done_single", done, 0);
    check("idle_after", busy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    for (int i = 0; i <= 67000; i++) mem[i] = 8'(i * 7 + 3);
    mem[100] = 8'h11; mem[101] = 8'h22; mem[102] = 8'h33; mem[103] = 8'h44;
    rst = 1'b1; start = 1'b0; out_ready = 1'b1; base_addr = '0; length = '0;
    @(negedge clk); @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_valid", out_valid, 0);
    check("rst_addr", ext_addr, 0);
    check("rst_data", out_data, 0);
    rst = 1'b0;

    // basic burst, then the same transfer under back-pressure
    run_xfer(100, 4, 0, 0);
    run_xfer(100, 4, 1, 0);

    // range check: 66998+3 = 67001 is out of range
    pulse_start(66998, 4);
    check("err_pulse", err, 1);
    check("err_busy", busy, 0);
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (out_valid || busy || err) seen++;
    end
    check("err_quiet", seen, 0);
    run_xfer(66997, 4, 0, 0);

    // zero length
    pulse_start(300, 0);
    check("len0_done", done, 1);
    check("len0_busy", busy, 0);
    check("len0_valid", out_valid, 0);
    @(negedge clk);
    check("len0_done_clr", done, 0);
    check("len0_valid2", out_valid, 0);

    // reset mid-transfer
    out_ready = 1'b1;
    pulse_start(200, 16);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_err", err, 0);
    check("abort_addr", ext_addr, 0);
    check("abort_valid", out_valid, 0);
    check("abort_last", out_last, 0);
    check("abort_data", out_data, 0);
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (done || out_valid || busy) seen++;
    end
    check("abort_quiet", seen, 0);
    run_xfer(0, 2, 0, 0);

    // start while busy is ignored
    run_xfer(100, 4, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
